// File: rtl/wb_reg_responder_pkg.sv
// Shared types and constants for the Wishbone register responder.
// Holds the FSM encoding, the wait-counter width and the index-width helper.
package wb_reg_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WCW = 4;

  // Register index width; never narrower than one bit so a single-register bank still decodes.
  function automatic int IDXW(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/wb_reg_responder_if.sv
// Wishbone classic bus bundle between master and the register responder.
// wb_err_o exists only when WB_REG_RESPONDER_ERR_EN is defined.
interface wb_reg_responder_if #(
  parameter int AW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
`ifdef WB_REG_RESPONDER_ERR_EN
  logic          wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
`else
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
`endif
endinterface

// File: rtl/wb_reg_responder_sel.sv
// Byte-lane merge for the write path: each lane takes the new byte when its
// sel bit is set, otherwise keeps the old byte.
module wb_sel_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  sel,
  output logic [31:0] merged_word
);
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = sel[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
  end
endmodule

// File: rtl/wb_reg_responder.sv
// Wishbone classic register responder with programmable wait states.
// Define WB_REG_RESPONDER_ERR_EN to answer out-of-range accesses with wb_err_o.
module wb_reg_responder
  import wb_reg_responder_pkg::*;
#(
  parameter int AW    = 32,
  parameter int NREGS = 4,
  parameter int WAIT  = 0
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  wb_reg_responder_if.slave     bus,
  output logic [NREGS*32-1:0]   regs_o
);
  localparam int IW = IDXW(NREGS);
  localparam int WW = AW - 2;
  localparam logic [WW-1:0] NREGS_W = WW'(NREGS);

  state_t         state_reg, state_next;
  logic [WCW-1:0] cnt_reg, cnt_next;
  logic [WW-1:0]  word_reg;
  logic           we_reg;
  logic [3:0]     sel_reg;
  logic [31:0]    wdat_reg;
  logic [31:0]    dat_reg, dat_next;
  logic [31:0]    bank_reg [NREGS];

  logic           accept;
  logic [WW-1:0]  bus_word, src_word;
  logic           src_we, src_in, in_range;
  logic [31:0]    rd_word, old_word, merged_word;
  logic           unused_adr;

  assign bus_word   = bus.wb_adr_i[AW-1:2];
  assign unused_adr = ^bus.wb_adr_i[1:0];
  assign in_range   = (word_reg < NREGS_W);

  // With WAIT=0 the RESP entry happens straight from IDLE, before the request is latched.
  assign src_word = (state_reg == ST_IDLE) ? bus_word : word_reg;
  assign src_we   = (state_reg == ST_IDLE) ? bus.wb_we_i : we_reg;
  assign src_in   = (src_word < NREGS_W);
  assign rd_word  = (!src_we && src_in) ? bank_reg[src_word[IW-1:0]] : '0;
  assign old_word = in_range ? bank_reg[word_reg[IW-1:0]] : '0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          accept     = 1'b1;
          state_next = (WAIT > 0) ? ST_WAIT : ST_RESP;
          cnt_next   = (WAIT > 0) ? WCW'(WAIT - 1) : '0;
        end
      end
      ST_WAIT: begin
        if (!bus.wb_cyc_i) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == '0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    dat_next = (state_next == ST_RESP) ? rd_word : '0;
  end

  wb_sel_merge u_merge (
    .old_word    (old_word),
    .new_word    (wdat_reg),
    .sel         (sel_reg),
    .merged_word (merged_word)
  );

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      wdat_reg  <= '0;
      dat_reg   <= '0;
      for (int k = 0; k < NREGS; k++) bank_reg[k] <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dat_reg   <= dat_next;
      if (accept) begin
        word_reg <= bus_word;
        we_reg   <= bus.wb_we_i;
        sel_reg  <= bus.wb_sel_i;
        wdat_reg <= bus.wb_dat_i;
      end
      if (state_reg == ST_RESP && we_reg && in_range)
        bank_reg[word_reg[IW-1:0]] <= merged_word;
    end
  end

  assign bus.wb_dat_o = dat_reg;
`ifdef WB_REG_RESPONDER_ERR_EN
  assign bus.wb_ack_o = (state_reg == ST_RESP) && in_range;
  assign bus.wb_err_o = (state_reg == ST_RESP) && !in_range;
`else
  assign bus.wb_ack_o = (state_reg == ST_RESP);
`endif

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    assign regs_o[32*gi +: 32] = bank_reg[gi];
  end

endmodule

// File: tb/tb_wb_reg_responder.sv
// Directed bench for wb_reg_responder: three instances with WAIT = 0, 3, 5
// sharing address/data/we/sel, each with its own cyc/stb.
module tb_wb_reg_responder;
  localparam int NREGS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cyc, stb;
  logic [2:0]  ack_w, err_w;
  logic [2:0][31:0]         rdat_w;
  logic [2:0][NREGS*32-1:0] regs_w;

  int n_vec  = 0;
  int n_miss = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WT = (gi == 0) ? 0 : (gi == 1) ? 3 : 5;
    wb_reg_responder_if #(.AW(32)) bus ();
    assign bus.wb_adr_i = adr;
    assign bus.wb_dat_i = dat;
    assign bus.wb_sel_i = sel;
    assign bus.wb_we_i  = we;
    assign bus.wb_cyc_i = cyc[gi];
    assign bus.wb_stb_i = stb[gi];
    assign ack_w[gi]    = bus.wb_ack_o;
    assign rdat_w[gi]   = bus.wb_dat_o;
`ifdef WB_REG_RESPONDER_ERR_EN
    assign err_w[gi]    = bus.wb_err_o;
`else
    assign err_w[gi]    = 1'b0;
`endif
    wb_reg_responder #(.AW(32), .NREGS(NREGS), .WAIT(WT)) dut (
      .wb_clk (clk),
      .wb_rst (rst),
      .bus    (bus),
      .regs_o (regs_w[gi])
    );
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end else begin
      $display("  ok %s: %0h", tag, got);
    end
  endtask

  // One transfer on instance u; lat counts edges from request to ack/err (0 = timed out).
  task automatic xfer(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output logic got_ack, output logic got_err, output logic resp_after);
    adr = a; dat = d; sel = s; we = w; cyc[u] = 1'b1; stb[u] = 1'b1;
    lat = 0; rd = '0; got_ack = 1'b0; got_err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack_w[u] || err_w[u]) begin
        lat = i; rd = rdat_w[u]; got_ack = ack_w[u]; got_err = err_w[u];
        break;
      end
    end
    cyc[u] = 1'b0; stb[u] = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    resp_after = ack_w[u] | err_w[u];
  endtask

  logic [31:0] rd;
  int          lat;
  logic        ga, ge, ra;
  logic [5:0]  pat;
  int          late_acks;

  initial begin
    adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = '0; stb = '0;
    #2 rst = 1'b1;
    #1;
    check_val("rst_ack", ack_w, 3'b000);
    check_val("rst_dat", rdat_w[0], 32'h0);
    check_val("rst_regs", regs_w[0], 128'h0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // WAIT=0 write then read of word 1
    xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, lat, ga, ge, ra);
    check_val("w0_wr_lat", lat, 1);
    check_val("w0_wr_ack_once", ra, 1'b0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ga, ge, ra);
    check_val("w0_rd_lat", lat, 1);
    check_val("w0_rd_dat", rd, 32'hDEADBEEF);
    check_val("w0_regs1", regs_w[0][63:32], 32'hDEADBEEF);
    check_val("w0_dat_clr", rdat_w[0], 32'h0);

    // WAIT=3 read of reset register
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, lat, ga, ge, ra);
    check_val("w3_rd_lat", lat, 4);
    check_val("w3_rd_dat", rd, 32'h0);
    check_val("w3_ack_once", ra, 1'b0);

    // Partial writes on word 2
    xfer(0, 1'b1, 32'h8, 32'h11223344, 4'hF, rd, lat, ga, ge, ra);
    xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, lat, ga, ge, ra);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, lat, ga, ge, ra);
    check_val("sel0101_rd", rd, 32'h11BB33DD);
    xfer(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, lat, ga, ge, ra);
    check_val("sel0000_lat", lat, 1);
    check_val("sel0000_reg", regs_w[0][95:64], 32'h11BB33DD);

    // adr[1:0] ignored: 0xF decodes to word 3
    xfer(0, 1'b1, 32'hF, 32'h01020304, 4'hF, rd, lat, ga, ge, ra);
    check_val("lowbits_reg3", regs_w[0][127:96], 32'h01020304);

    // stb held high: acks spaced WAIT+2 = 2 cycles apart
    adr = 32'h4; we = 1'b0; sel = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1; pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = ack_w[0];
    end
    check_val("b2b_dat", rdat_w[0], 32'h0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check_val("b2b_acks", pat, 6'b010101);
    @(posedge clk); #1;

    // Out-of-range word 4
    xfer(0, 1'b1, 32'h10, 32'h55555555, 4'hF, rd, lat, ga, ge, ra);
    check_val("oor_wr_lat", lat, 1);
`ifdef WB_REG_RESPONDER_ERR_EN
    check_val("oor_wr_ackerr", {ga, ge}, 2'b01);
`else
    check_val("oor_wr_ackerr", {ga, ge}, 2'b10);
`endif
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ga, ge, ra);
    check_val("oor_rd_dat", rd, 32'h0);
`ifdef WB_REG_RESPONDER_ERR_EN
    check_val("oor_rd_ackerr", {ga, ge}, 2'b01);
`else
    check_val("oor_rd_ackerr", {ga, ge}, 2'b10);
`endif
    check_val("oor_regs", regs_w[0], {32'h01020304, 32'h11BB33DD, 32'hDEADBEEF, 32'h0});

    // WAIT=5 abort in the middle of the wait phase
    xfer(2, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, lat, ga, ge, ra);
    check_val("w5_wr_lat", lat, 6);
    adr = 32'h8; dat = 32'h12345678; sel = 4'hF; we = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we = 1'b0;
    late_acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_w[2] || err_w[2]) late_acks++;
    end
    check_val("abort_no_ack", late_acks, 0);
    check_val("abort_reg2", regs_w[2][95:64], 32'hCAFEF00D);
    xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, rd, lat, ga, ge, ra);
    check_val("abort_next_lat", lat, 6);
    check_val("abort_next_dat", rd, 32'hCAFEF00D);

    // Reset asserted while instance 1 is waiting
    xfer(1, 1'b1, 32'hC, 32'h0BADF00D, 4'hF, rd, lat, ga, ge, ra);
    check_val("w3_wr_reg3", regs_w[1][127:96], 32'h0BADF00D);
    adr = 32'hC; dat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("midrst_ack", ack_w[1], 1'b0);
    check_val("midrst_dat", rdat_w[1], 32'h0);
    check_val("midrst_regs1", regs_w[1], 128'h0);
    check_val("midrst_regs0", regs_w[0], 128'h0);
`ifdef WB_REG_RESPONDER_ERR_EN
    check_val("midrst_err", err_w[1], 1'b0);
`endif
    cyc[1] = 1'b0; stb[1] = 1'b0; we = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ga, ge, ra);
    check_val("postrst_lat", lat, 4);
    check_val("postrst_dat", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
